reg_write_queue: RTL and testbench

//   Write-request buffer that sits directly upstream of the register file storage (per-register FF array).
//   It accepts (addr, data) write requests over a valid/ready handshake and buffers them in a circular queue.
//   It drains one entry per cycle into the register file write port (address decode + FF enable/d).
//   A combinational read bypass returns the youngest pending value, so readers never see stale FF contents.
//

---
 rtl/reg_write_queue.sv | 103 ++++++++++
 tb/tb_reg_write_queue.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_queue.sv
// Circular write-request buffer in front of the register file FF array.
// Drains one entry per cycle and offers a youngest-match read bypass.
module reg_write_queue #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     rf_busy,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [WIDTH-1:0]         wr_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic                     rd_hit,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [WIDTH-1:0]  data_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;
  logic [PTR_W-1:0]  idx;

  // Handshake and drain; reset gates everything so outputs are 0 during reset.
  always_comb begin
    in_ready = reset & (count_q < CNT_W'(DEPTH));
    // Writes to register 0 complete the handshake but are dropped.
    push     = in_valid & in_ready & (in_addr != '0);
    wr_en    = reset & (count_q != '0) & ~rf_busy;
    pop      = wr_en;
    wr_addr  = '0;
    wr_data  = '0;
    if (reset && (count_q != '0)) begin
      wr_addr = addr_q[head_q];
      wr_data = data_q[head_q];
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    if (push) begin
      tail_d = tail_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    idx     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (reset && (CNT_W'(i) < count_q) && (rd_addr != '0) && (addr_q[idx] == rd_addr)) begin
        rd_hit  = 1'b1;
        rd_data = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        addr_q[tail_q] <= in_addr;
        data_q[tail_q] <= in_data;
      end
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_reg_write_queue.sv
// Bench for reg_write_queue: directed steps plus random traffic against a queue-based model.
module tb_reg_write_queue;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [WIDTH-1:0]  in_data;
  logic              rf_busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_hit;
  logic [WIDTH-1:0]  rd_data;
  logic [$clog2(DEPTH):0] count;

  reg_write_queue #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .rf_busy  (rf_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr  (rd_addr),
    .rd_hit   (rd_hit),
    .rd_data  (rd_data),
    .count    (count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } ent_t;

  ent_t q[$];
  int   tests  = 0;
  int   failed = 0;
  logic pre_ready, pre_wen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow directly from the pending-write list.
  task automatic check_outputs(input string ph);
    logic              e_ready, e_wen, e_hit;
    logic [ADDR_W-1:0] e_waddr;
    logic [WIDTH-1:0]  e_wdata, e_rdata;
    int                n;
    n = q.size();
    e_ready = 0; e_wen = 0; e_hit = 0; e_waddr = '0; e_wdata = '0; e_rdata = '0;
    if (reset) begin
      e_ready = (n < DEPTH);
      e_wen   = (n != 0) && !rf_busy;
      if (n != 0) begin
        e_waddr = q[0].addr;
        e_wdata = q[0].data;
      end
      for (int i = 0; i < n; i++) begin
        if (rd_addr != 0 && q[i].addr == rd_addr) begin
          e_hit   = 1;
          e_rdata = q[i].data;
        end
      end
    end
    chk({ph, ".count"},    64'(count),    64'(reset ? n : 0));
    chk({ph, ".in_ready"}, 64'(in_ready), 64'(e_ready));
    chk({ph, ".wr_en"},    64'(wr_en),    64'(e_wen));
    chk({ph, ".wr_addr"},  64'(wr_addr),  64'(e_waddr));
    chk({ph, ".wr_data"},  64'(wr_data),  64'(e_wdata));
    chk({ph, ".rd_hit"},   64'(rd_hit),   64'(e_hit));
    chk({ph, ".rd_data"},  64'(rd_data),  64'(e_rdata));
    pre_ready = e_ready;
    pre_wen   = e_wen;
  endtask

  task automatic model_update();
    ent_t e;
    if (!reset) begin
      q.delete();
    end else begin
      if (pre_wen) void'(q.pop_front());
      if (in_valid && pre_ready && in_addr != 0) begin
        e.addr = in_addr;
        e.data = in_data;
        q.push_back(e);
      end
    end
  endtask

  // Check mid-cycle, commit the model at the edge, then leave inputs 1 unit after the edge.
  task automatic step(input string ph);
    @(negedge clk);
    check_outputs(ph);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(input logic v, input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
  endtask

  initial begin
    reset = 1; in_valid = 0; in_addr = '0; in_data = '0; rf_busy = 0; rd_addr = '0;
    #1 reset = 0;
    step("rst");
    step("rst");
    reset = 1;

    // Idle after reset: no hits anywhere
    for (int a = 0; a < 32; a++) begin
      rd_addr = ADDR_W'(a);
      step("t1");
    end

    // Single push drains on the next cycle
    drive(1, 5'd3, 32'hDEADBEEF);
    step("t2.push");
    drive(0, '0, '0);
    rd_addr = 5'd3;
    #1;
    chk("t2.wr_en", 64'(wr_en), 64'd1);
    chk("t2.wr_data", 64'(wr_data), 64'hDEADBEEF);
    step("t2.drain");
    step("t2.empty");

    // Fill under rf_busy, bypass returns youngest, drain order preserved
    rf_busy = 1;
    drive(1, 5'd1, 32'h11); step("t3.p0");
    drive(1, 5'd2, 32'h22); step("t3.p1");
    drive(1, 5'd1, 32'h33); step("t3.p2");
    drive(1, 5'd5, 32'h55); step("t3.p3");
    drive(0, '0, '0);
    rd_addr = 5'd1;
    #1;
    chk("t3.count_full", 64'(count), 64'd4);
    chk("t3.in_ready_full", 64'(in_ready), 64'd0);
    chk("t3.rd_data_young", 64'(rd_data), 64'h33);
    step("t3.hold");
    step("t3.hold");
    rf_busy = 0;
    for (int i = 0; i < 5; i++) step("t3.drain");

    // Full queue: pop edge does not accept, next edge does
    rf_busy = 1;
    for (int i = 0; i < 4; i++) begin
      drive(1, ADDR_W'(i + 8), 32'h100 + i);
      step("t4.fill");
    end
    drive(1, 5'd20, 32'hABCD);
    rf_busy = 0;
    #1;
    chk("t4.ready_full", 64'(in_ready), 64'd0);
    step("t4.popedge");
    #1;
    chk("t4.count_after_pop", 64'(count), 64'd3);
    step("t4.pushedge");
    #1;
    chk("t4.count_pushpop", 64'(count), 64'd3);
    // Wrap over 3*DEPTH pushes
    for (int i = 0; i < 3 * DEPTH; i++) begin
      rf_busy = (i % 3 == 0);
      drive(1, ADDR_W'(i % 7 + 1), 32'hC000 + i);
      rd_addr = ADDR_W'(i % 7 + 1);
      step("t4.wrap");
    end
    drive(0, '0, '0);
    rf_busy = 0;
    for (int i = 0; i < DEPTH + 1; i++) step("t4.flush");

    // Register 0 writes are swallowed
    drive(1, 5'd0, 32'hFFFFFFFF);
    #1;
    chk("t5.ready", 64'(in_ready), 64'd1);
    step("t5.push0");
    drive(0, '0, '0);
    #1;
    chk("t5.count", 64'(count), 64'd0);
    chk("t5.wr_en", 64'(wr_en), 64'd0);
    rd_addr = 5'd0;
    step("t5.idle");
    step("t5.idle");

    // Async reset with entries pending
    rf_busy = 1;
    drive(1, 5'd7, 32'h77); step("t6.p0");
    drive(1, 5'd8, 32'h88); step("t6.p1");
    drive(1, 5'd9, 32'h99); step("t6.p2");
    drive(0, '0, '0);
    rf_busy = 0;
    rd_addr = 5'd7;
    #1 reset = 0;
    #1;
    q.delete();
    chk("t6.count_rst", 64'(count), 64'd0);
    chk("t6.wr_en_rst", 64'(wr_en), 64'd0);
    chk("t6.rd_hit_rst", 64'(rd_hit), 64'd0);
    chk("t6.ready_rst", 64'(in_ready), 64'd0);
    step("t6.inrst");
    reset = 1;
    for (int i = 0; i < 4; i++) step("t6.after");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rf_busy = ($urandom_range(0, 3) == 0);
      drive($urandom_range(0, 1) == 1, ADDR_W'($urandom_range(0, 7)), $urandom);
      rd_addr = ADDR_W'($urandom_range(0, 7));
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
